pwm_frame_packer: RTL and testbench
===================================

// Module: pwm_frame_packer
// PURPOSE
//  Upstream feeder for the PWM generator. Captures 32-bit ON/OFF period writes from the periplex config bus.
//  On commit, serialises the 64-bit frame {OFF,ON} MSB-first into an internal 8-bit FIFO.
//  The FIFO read side connects directly to the generator's empty/read/i_data inputs.
// PARAMETERS
//  PERIOD_WIDTH  32  width of each ON/OFF period register; 2*PERIOD_WIDTH must be a multiple of 8
//  FIFO_DEPTH    16  byte FIFO depth; power of two, >= 8 (16 = two queued frames)
//  FIFO_AW       4   log2(FIFO_DEPTH)
// PORTS
//  clk         in   1                 system clock
//  rst_n       in   1                 reset; synchronous, active-low
//  cfg_wr_en   in   1                 config write strobe, one cycle per write
//  cfg_addr    in   2                 0=ON period, 1=OFF period, 2=COMMIT, 3=FLUSH
//  cfg_wdata   in   PERIOD_WIDTH      write data; ignored for addr 2 and 3
//  busy        out  1                 frame serialisation in progress
//  err         out  2                 sticky; [0]=commit while busy, [1]=zero period (see CONFIGURATION)
//  fifo_empty  out  1                 FIFO has no bytes (to generator 'empty')
//  fifo_read   in   1                 pop request from generator
//  fifo_data   out  8                 registered pop data (to generator 'i_data')
//  fifo_level  out  FIFO_AW+1         bytes currently stored
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): on_reg=off_reg=0; FIFO emptied; state=IDLE.
//   Output reset values: busy=0, err=0, fifo_empty=1, fifo_data=0, fifo_level=0.
//   Reset mid-frame discards the partial frame.
//  Writes: addr0 -> on_reg, addr1 -> off_reg; writes are legal in any state.
//   Shadow copies are not disturbed mid-frame.
//  FSM: IDLE, PUSH, DONE.
//   IDLE: COMMIT snapshots frame={off_reg,on_reg} into shift_reg, clears byte_cnt, next=PUSH.
//   PUSH: each cycle with FIFO not full, write shift_reg[63:56], shift left 8, byte_cnt++.
//    If the FIFO is full, stall with no write and no loss. After byte 7 is written, next=DONE.
//   DONE: one cycle, busy drops, next=IDLE.
//  busy=1 in PUSH and DONE. Commit-to-first-byte latency is 1 cycle; an unstalled frame takes 8 push cycles.
//  COMMIT while busy: ignored, err[0] set.
//  FLUSH: any state -> IDLE. Clears FIFO, byte_cnt, and err. on_reg/off_reg are kept.
//   FLUSH in the same cycle as fifo_read: the flush wins and the read is ignored.
//  Byte order: off[31:24], off[23:16], off[15:8], off[7:0], on[31:24], ... on[7:0].
//   The consumer's left-shift accumulation therefore yields o_data[63:32]=OFF and [31:0]=ON.
//  FIFO:
//   - Pointers are FIFO_AW+1 bits and wrap modulo 2*FIFO_DEPTH. full = (level==FIFO_DEPTH).
//   - fifo_read with !fifo_empty pops; fifo_data updates on the next clk edge and holds until the next pop.
//   - fifo_read while empty is ignored; fifo_data holds.
//   - Push and pop in the same cycle are allowed: level unchanged.
//   - full is evaluated before the pop; there is no bypass.
//   - fifo_empty and fifo_level are registered and reflect the previous edge's push/pop.
// CONFIGURATION
//  PWM_PACKER_ZERO_CHECK_EN defined:
//   COMMIT with on_reg==0 or off_reg==0 is rejected: no push, stays IDLE, err[1] set.
//  Not defined: zero periods are accepted and pushed; err[1] is tied to 0.
// STRUCTURE
//  Shared package pwm_pkg:
//   - CFG_ADDR_ON/OFF/COMMIT/FLUSH constants
//   - state encodings IDLE/PUSH/DONE
//   - PWM_FRAME_BYTES=8
//  Sub-module pwm_byte_fifo (param depth/width, sync clear, registered read data).
//   Packer FSM and registers stay in the top module.
// TESTING
//  1 reset: hold rst_n=0 three cycles -> busy=0, err=0, fifo_empty=1, fifo_level=0, fifo_data=0
//  2 write ON=0x00000064, OFF=0x000000C8, COMMIT, no reads
//    -> 8 cycles later fifo_level=8, popped bytes 00,00,00,C8,00,00,00,64
//  3 three frames with no reads, FIFO_DEPTH=16
//    -> second frame fills (level=16); third COMMIT while busy sets err[0]; no byte lost or duplicated
//  4 fill to 16, then pop one byte per cycle
//    -> packer resumes; same-cycle push+pop keeps level constant; all bytes in order
//  5 FLUSH at byte 3 of a frame
//    -> level=0, fifo_empty=1, busy=0, err=0; next COMMIT pushes a full 8-byte frame
//  6 ZERO_CHECK_EN: ON=0, COMMIT -> err[1]=1, level unchanged; without the macro -> 8 bytes pushed

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM frame packer.
package pwm_pkg;

    localparam logic [1:0] CFG_ADDR_ON     = 2'd0;
    localparam logic [1:0] CFG_ADDR_OFF    = 2'd1;
    localparam logic [1:0] CFG_ADDR_COMMIT = 2'd2;
    localparam logic [1:0] CFG_ADDR_FLUSH  = 2'd3;

    localparam int PWM_FRAME_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        DONE = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_byte_fifo.sv
// Byte FIFO with synchronous clear, registered pop data and registered empty/level.
module pwm_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level
);

    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];
    localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      level_r;
    logic [AW:0]      level_next_s;
    logic [WIDTH-1:0] rd_data_r;
    logic             empty_r;
    logic             do_wr_s;
    logic             do_rd_s;

    // Accept/pop qualification; full is taken from the pre-pop level, so no bypass.
    always_comb begin
        do_wr_s      = 1'b0;
        do_rd_s      = 1'b0;
        level_next_s = level_r;
        if (!clr) begin
            do_wr_s = wr_en && (level_r != FULL_LEVEL);
            do_rd_s = rd_en && !empty_r;
        end else begin
            do_wr_s = 1'b0;
            do_rd_s = 1'b0;
        end
        case ({do_wr_s, do_rd_s})
            2'b10:   level_next_s = level_r + PTR_ONE;
            2'b01:   level_next_s = level_r - PTR_ONE;
            default: level_next_s = level_r;
        endcase
    end

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Pointer, level, flag and read-data registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            level_r   <= '0;
            empty_r   <= 1'b1;
            rd_data_r <= '0;
        end else if (clr) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            level_r   <= '0;
            empty_r   <= 1'b1;
            rd_data_r <= '0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_rd_s) begin
                rd_ptr_r  <= rd_ptr_r + PTR_ONE;
                rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
            end
            level_r <= level_next_s;
            empty_r <= (level_next_s == '0);
        end
    end

    assign rd_data = rd_data_r;
    assign empty   = empty_r;
    assign full    = (level_r == FULL_LEVEL);
    assign level   = level_r;

endmodule

// File: rtl/pwm_frame_packer.sv
// Captures ON/OFF periods and serialises {OFF,ON} MSB-first into a byte FIFO.
// Optional feature macro: PWM_PACKER_ZERO_CHECK_EN rejects commits with a zero period.
module pwm_frame_packer
    import pwm_pkg::*;
#(
    parameter int PERIOD_WIDTH = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int FIFO_AW      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_wr_en,
    input  logic [1:0]              cfg_addr,
    input  logic [PERIOD_WIDTH-1:0] cfg_wdata,
    output logic                    busy,
    output logic [1:0]              err,
    output logic                    fifo_empty,
    input  logic                    fifo_read,
    output logic [7:0]              fifo_data,
    output logic [FIFO_AW:0]        fifo_level
);

    localparam int FRAME_W     = 2 * PERIOD_WIDTH;
    localparam int FRAME_BYTES = FRAME_W / 8;
    localparam int CNT_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    pwm_state_e              state_r;
    logic [PERIOD_WIDTH-1:0] on_r;
    logic [PERIOD_WIDTH-1:0] off_r;
    logic [FRAME_W-1:0]      shift_r;
    logic [CNT_W-1:0]        byte_cnt_r;
    logic                    busy_r;
    logic [1:0]              err_r;
    logic                    commit_s;
    logic                    flush_s;
    logic                    push_s;
    logic                    fifo_full_s;

    // Decode of config strobes and the per-cycle push decision.
    always_comb begin
        commit_s = cfg_wr_en && (cfg_addr == CFG_ADDR_COMMIT);
        flush_s  = cfg_wr_en && (cfg_addr == CFG_ADDR_FLUSH);
        if ((state_r == PUSH) && !fifo_full_s && !flush_s) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Period registers, frame shifter and packer FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            on_r       <= '0;
            off_r      <= '0;
            shift_r    <= '0;
            byte_cnt_r <= '0;
            busy_r     <= 1'b0;
            err_r      <= 2'b00;
        end else begin
            if (cfg_wr_en && (cfg_addr == CFG_ADDR_ON)) begin
                on_r <= cfg_wdata;
            end
            if (cfg_wr_en && (cfg_addr == CFG_ADDR_OFF)) begin
                off_r <= cfg_wdata;
            end

            if (flush_s) begin
                state_r    <= IDLE;
                byte_cnt_r <= '0;
                busy_r     <= 1'b0;
                err_r      <= 2'b00;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (commit_s) begin
`ifdef PWM_PACKER_ZERO_CHECK_EN
                            if ((on_r == '0) || (off_r == '0)) begin
                                err_r[1] <= 1'b1;
                            end else begin
                                shift_r    <= {off_r, on_r};
                                byte_cnt_r <= '0;
                                busy_r     <= 1'b1;
                                state_r    <= PUSH;
                            end
`else
                            shift_r    <= {off_r, on_r};
                            byte_cnt_r <= '0;
                            busy_r     <= 1'b1;
                            state_r    <= PUSH;
`endif
                        end
                    end
                    PUSH: begin
                        if (commit_s) begin
                            err_r[0] <= 1'b1;
                        end
                        // A full FIFO simply holds the shifter; the byte is retried next cycle.
                        if (push_s) begin
                            shift_r    <= {shift_r[FRAME_W-9:0], 8'h00};
                            byte_cnt_r <= byte_cnt_r + CNT_ONE;
                            if (byte_cnt_r == LAST_BYTE) begin
                                state_r <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (commit_s) begin
                            err_r[0] <= 1'b1;
                        end
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                    default: begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    pwm_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush_s),
        .wr_en   (push_s),
        .wr_data (shift_r[FRAME_W-1 -: 8]),
        .rd_en   (fifo_read),
        .rd_data (fifo_data),
        .empty   (fifo_empty),
        .full    (fifo_full_s),
        .level   (fifo_level)
    );

    assign busy = busy_r;
    assign err  = err_r;

endmodule

// File: tb/tb_pwm_frame_packer.sv
// Scoreboard bench for pwm_frame_packer: stimulus queues expected bytes, a monitor checks pops.
module tb_pwm_frame_packer;
    import pwm_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cfg_wr_en;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        busy;
    logic [1:0]  err;
    logic        fifo_empty;
    logic        fifo_read;
    logic [7:0]  fifo_data;
    logic [4:0]  fifo_level;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb_q[$];

    pwm_frame_packer #(.PERIOD_WIDTH(32), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_wr_en  (cfg_wr_en),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .busy       (busy),
        .err        (err),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .fifo_data  (fifo_data),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sb_push_frame(input logic [31:0] off, input logic [31:0] on);
        logic [63:0] frame;
        frame = {off, on};
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(frame[63 - 8*i -: 8]);
        end
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        cfg_wr_en = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(negedge clk);
        cfg_wr_en = 1'b0;
        cfg_wdata = 32'h0;
    endtask

    task automatic commit(input logic [31:0] off, input logic [31:0] on, input bit expect_push);
        if (expect_push) sb_push_frame(off, on);
        cfg_write(CFG_ADDR_COMMIT, 32'h0);
    endtask

    task automatic flush();
        sb_q.delete();
        cfg_write(CFG_ADDR_FLUSH, 32'h0);
    endtask

    task automatic pop_cycles(input int n);
        fifo_read = 1'b1;
        repeat (n) @(negedge clk);
        fifo_read = 1'b0;
    endtask

    // Monitor: every accepted pop must deliver the oldest expected byte.
    initial begin
        logic       pop_seen;
        logic [7:0] exp_b;
        forever begin
            @(posedge clk);
            pop_seen = rst_n && fifo_read && !fifo_empty &&
                       !(cfg_wr_en && (cfg_addr == CFG_ADDR_FLUSH));
            @(negedge clk);
            if (pop_seen) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected actual=%0h required=none", fifo_data);
                end else begin
                    exp_b = sb_q.pop_front();
                    check("pop_byte", {56'h0, fifo_data}, {56'h0, exp_b});
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        cfg_wr_en = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 32'h0;
        fifo_read = 1'b0;

        // 1: reset
        repeat (3) @(negedge clk);
        check("rst_busy",  {63'h0, busy},       64'h0);
        check("rst_err",   {62'h0, err},        64'h0);
        check("rst_empty", {63'h0, fifo_empty}, 64'h1);
        check("rst_level", {59'h0, fifo_level}, 64'h0);
        check("rst_data",  {56'h0, fifo_data},  64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 2: single frame, latency and byte order
        cfg_write(CFG_ADDR_ON,  32'h0000_0064);
        cfg_write(CFG_ADDR_OFF, 32'h0000_00C8);
        commit(32'h0000_00C8, 32'h0000_0064, 1'b1);
        @(negedge clk);
        check("lat1_level", {59'h0, fifo_level}, 64'h1);
        check("lat1_busy",  {63'h0, busy},       64'h1);
        repeat (7) @(negedge clk);
        check("f1_level", {59'h0, fifo_level}, 64'h8);
        @(negedge clk);
        @(negedge clk);
        check("f1_idle", {63'h0, busy}, 64'h0);
        pop_cycles(8);
        @(negedge clk);
        check("f1_empty", {63'h0, fifo_empty}, 64'h1);
        check("f1_last",  {56'h0, fifo_data},  64'h64);

        // 3: two frames fill the FIFO, a third commit while busy is rejected
        cfg_write(CFG_ADDR_ON,  32'h1122_3344);
        cfg_write(CFG_ADDR_OFF, 32'h5566_7788);
        commit(32'h5566_7788, 32'h1122_3344, 1'b1);
        repeat (9) @(negedge clk);
        cfg_write(CFG_ADDR_ON,  32'hA1A2_A3A4);
        cfg_write(CFG_ADDR_OFF, 32'hB1B2_B3B4);
        commit(32'hB1B2_B3B4, 32'hA1A2_A3A4, 1'b1);
        commit(32'hB1B2_B3B4, 32'hA1A2_A3A4, 1'b0);
        check("busy_commit_err", {62'h0, err}, 64'h1);
        repeat (9) @(negedge clk);
        check("full_level", {59'h0, fifo_level}, 64'h10);
        check("full_idle",  {63'h0, busy},       64'h0);

        // 4: commit into a full FIFO stalls, then drain with concurrent push
        cfg_write(CFG_ADDR_ON,  32'hC0C1_C2C3);
        cfg_write(CFG_ADDR_OFF, 32'hD0D1_D2D3);
        commit(32'hD0D1_D2D3, 32'hC0C1_C2C3, 1'b1);
        repeat (3) @(negedge clk);
        check("stall_level", {59'h0, fifo_level}, 64'h10);
        check("stall_busy",  {63'h0, busy},       64'h1);
        pop_cycles(3);
        check("pushpop_level", {59'h0, fifo_level}, 64'hF);
        pop_cycles(2);
        check("pushpop_level2", {59'h0, fifo_level}, 64'hF);
        pop_cycles(30);
        check("drain_level", {59'h0, fifo_level}, 64'h0);
        check("drain_busy",  {63'h0, busy},       64'h0);
        check("err_sticky",  {62'h0, err},        64'h1);

        // 5: flush mid-frame
        cfg_write(CFG_ADDR_ON,  32'h0102_0304);
        cfg_write(CFG_ADDR_OFF, 32'h0506_0708);
        commit(32'h0506_0708, 32'h0102_0304, 1'b1);
        repeat (2) @(negedge clk);
        flush();
        check("flush_level", {59'h0, fifo_level}, 64'h0);
        check("flush_empty", {63'h0, fifo_empty}, 64'h1);
        check("flush_busy",  {63'h0, busy},       64'h0);
        check("flush_err",   {62'h0, err},        64'h0);
        commit(32'h0506_0708, 32'h0102_0304, 1'b1);
        repeat (9) @(negedge clk);
        check("post_flush_level", {59'h0, fifo_level}, 64'h8);
        pop_cycles(8);

        // 6: zero ON period
        cfg_write(CFG_ADDR_ON, 32'h0);
`ifdef PWM_PACKER_ZERO_CHECK_EN
        commit(32'h0506_0708, 32'h0, 1'b0);
        repeat (9) @(negedge clk);
        check("zero_err",   {62'h0, err},        64'h2);
        check("zero_level", {59'h0, fifo_level}, 64'h0);
        check("zero_busy",  {63'h0, busy},       64'h0);
`else
        commit(32'h0506_0708, 32'h0, 1'b1);
        repeat (9) @(negedge clk);
        check("zero_err",   {62'h0, err},        64'h0);
        check("zero_level", {59'h0, fifo_level}, 64'h8);
        pop_cycles(8);
`endif
        @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
